tt_lut_settled: RTL

- Parametrised, reprogrammable truth-table logic gate: N_IN inputs, one output, and a 2^N_IN-bit truth table.
- Adds behaviour beyond a fixed combinational gate:
  - a settle filter, so the output updates only after the inputs have been stable for SETTLE cycles;
  - a serial configuration port that loads a new truth table at run time.
- Sits between input stimulus and downstream logic in gate-level circuit models. Any gate function is selected by INIT or by a runtime load.

---
 rtl/tt_lut_settled_if.sv | 42 ++++
 rtl/tt_lut_settled.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tt_lut_settled_if.sv
// ---------------------------------------------------------------------------
// tt_lut_settled_if
// Bundles the logic inputs, the filtered output and the serial truth-table
// configuration port of tt_lut_settled.
//   in        : logic inputs, in[N_IN-1] is the MSB of the table index
//   out       : filtered gate output
//   out_valid : out reflects the current stable inputs and the active table
//   cfg_valid : configuration beat valid
//   cfg_ready : beat accepted when cfg_valid & cfg_ready
//   cfg_bit   : table bit, MSB first
//   cfg_last  : final beat of a load
//   cfg_done  : one-cycle pulse, new table committed
//   cfg_err   : one-cycle pulse, load aborted on a framing error
//   tt_active : readback of the active table
// master = stimulus side, slave = the gate itself.
// ---------------------------------------------------------------------------
interface tt_lut_settled_if #(
  parameter int N_IN = 3
);
  localparam int W = 1 << N_IN;

  logic [N_IN-1:0] in;
  logic            out;
  logic            out_valid;
  logic            cfg_valid;
  logic            cfg_ready;
  logic            cfg_bit;
  logic            cfg_last;
  logic            cfg_done;
  logic            cfg_err;
  logic [W-1:0]    tt_active;

  modport master (
    output in, cfg_valid, cfg_bit, cfg_last,
    input  out, out_valid, cfg_ready, cfg_done, cfg_err, tt_active
  );

  modport slave (
    input  in, cfg_valid, cfg_bit, cfg_last,
    output out, out_valid, cfg_ready, cfg_done, cfg_err, tt_active
  );
endinterface

// File: rtl/tt_lut_settled.sv
// ---------------------------------------------------------------------------
// tt_lut_settled
// Reprogrammable N_IN-input truth-table gate with a settle filter on the
// inputs and a serial configuration port for loading a new table.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : tt_lut_settled_if slave (inputs, filtered output, config port)
// The output only updates once the inputs have been sampled identical for
// SETTLE consecutive edges; shorter glitches never reach the output.
// ---------------------------------------------------------------------------
module tt_lut_settled #(
  parameter int                    N_IN   = 3,
  parameter int                    SETTLE = 4,
  parameter logic [(1<<N_IN)-1:0]  INIT   = 8'hF6
) (
  input  logic              clk,
  input  logic              reset,
  tt_lut_settled_if.slave   bus
);

  localparam int W  = 1 << N_IN;
  localparam int CW = $clog2(SETTLE + 1);
  localparam int BW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } cfgState_t;

  // Settle filter state
  logic [N_IN-1:0] r_inQ;
  logic [CW-1:0]   r_cnt;
  logic            r_out;
  logic            r_outValid;

  // Configuration state
  cfgState_t       r_state;
  logic [W-1:0]    r_shadow;
  logic [BW-1:0]   r_beatCnt;
  logic [W-1:0]    r_ttActive;
  logic            r_cfgDone;
  logic            r_cfgErr;

  logic [N_IN-1:0] w_idx;
  logic [CW-1:0]   w_nextCnt;
  logic            w_ready;
  logic            w_accept;
  logic [BW-1:0]   w_beatInc;
  cfgState_t       w_nextState;
  logic [W-1:0]    w_shadowNext;
  logic [BW-1:0]   w_beatNext;
  logic            w_commit;
  logic            w_err;

  // Table bit W-1-v is selected; for an all-ones W-1 that is simply ~v.
  assign w_idx = ~bus.in;

  // A change restarts the run at 1 (this edge is the first sample of the
  // new value); otherwise count up and saturate at SETTLE.
  always_comb begin
    w_nextCnt = r_cnt;
    if (bus.in != r_inQ) begin
      w_nextCnt = CW'(1);
    end else if (r_cnt != CW'(SETTLE)) begin
      w_nextCnt = r_cnt + CW'(1);
    end
  end

  // While saturated the output is re-evaluated every edge, so a table
  // commit propagates to out one edge after tt_active changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inQ      <= '0;
      r_cnt      <= '0;
      r_out      <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      r_inQ <= bus.in;
      r_cnt <= w_nextCnt;
      if (w_nextCnt == CW'(SETTLE)) begin
        r_out      <= r_ttActive[w_idx];
        r_outValid <= 1'b1;
      end else begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign w_ready   = (r_state != COMMIT);
  assign w_accept  = bus.cfg_valid & w_ready;
  assign w_beatInc = r_beatCnt + BW'(1);

  // Config FSM next state. A load is exactly W beats with cfg_last on the
  // final one; any other framing aborts, clears the shadow and returns to
  // IDLE so the next accepted beat starts over as beat 1.
  always_comb begin
    w_nextState  = r_state;
    w_shadowNext = r_shadow;
    w_beatNext   = r_beatCnt;
    w_commit     = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.cfg_last) begin
            w_err        = 1'b1;
            w_shadowNext = '0;
            w_beatNext   = '0;
          end else begin
            w_shadowNext = {r_shadow[W-2:0], bus.cfg_bit};
            w_beatNext   = BW'(1);
            w_nextState  = LOAD;
          end
        end
      end
      LOAD: begin
        if (w_accept) begin
          w_shadowNext = {r_shadow[W-2:0], bus.cfg_bit};
          w_beatNext   = w_beatInc;
          if (w_beatInc == BW'(W)) begin
            if (bus.cfg_last) begin
              w_beatNext  = '0;
              w_nextState = COMMIT;
            end else begin
              w_err = 1'b1;
            end
          end else if (bus.cfg_last) begin
            w_err = 1'b1;
          end
          if (w_err) begin
            w_shadowNext = '0;
            w_beatNext   = '0;
            w_nextState  = IDLE;
          end
        end
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_beatNext  = '0;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState  = IDLE;
        w_shadowNext = '0;
        w_beatNext   = '0;
      end
    endcase
  end

  // Config registers. cfg_done is registered so it rises together with
  // the new tt_active value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shadow   <= '0;
      r_beatCnt  <= '0;
      r_ttActive <= INIT;
      r_cfgDone  <= 1'b0;
      r_cfgErr   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_shadow  <= w_shadowNext;
      r_beatCnt <= w_beatNext;
      r_cfgDone <= w_commit;
      r_cfgErr  <= w_err;
      if (w_commit) begin
        r_ttActive <= r_shadow;
      end
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_outValid;
  assign bus.cfg_ready = w_ready;
  assign bus.cfg_done  = r_cfgDone;
  assign bus.cfg_err   = r_cfgErr;
  assign bus.tt_active = r_ttActive;

endmodule
